// File: rtl/axis_route_tagger_pkg.sv
// Shared definitions for the AXI-Stream route tagger: frame FSM encoding,
// statistics counter width and a saturating increment helper.
package axis_route_tagger_pkg;

    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        ST_HEAD = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Output register plus one-entry skid buffer. Upstream ready is a pure
// register, so no combinational path exists from m_ready to s_ready.
// Data registers carry no reset; only the valid/ready flags do.
module axis_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic             out_vld;
    logic             skid_vld;
    logic             rdy_q;
    logic [WIDTH-1:0] out_dat;
    logic [WIDTH-1:0] skid_dat;
    logic             load_out;
    logic             acc;

    assign load_out = !out_vld || m_ready;
    assign acc      = s_valid && rdy_q;

    // Control flags: output valid, skid occupancy and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b0;
        end else if (load_out) begin
            out_vld  <= skid_vld || acc;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b1;
        end else if (acc) begin
            skid_vld <= 1'b1;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q    <= !skid_vld;
        end
    end

    // Data path: output register refills from skid first, skid catches a beat while stalled
    always_ff @(posedge clk) begin
        if (load_out) begin
            out_dat <= skid_vld ? skid_dat : s_data;
        end else if (acc) begin
            skid_dat <= s_data;
        end
    end

    assign s_ready = rdy_q;
    assign m_data  = out_dat;
    assign m_valid = out_vld;

endmodule

// File: rtl/axis_route_tagger.sv
// AXI-Stream router tagger: looks up a key in the first beat of each frame
// against a small masked match table, prefixes the chosen port onto tdest,
// and either forwards the frame through a skid register or discards it.
module axis_route_tagger
    import axis_route_tagger_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int KEEP_ENABLE    = (DATA_WIDTH > 8),
    parameter int ID_ENABLE      = 0,
    parameter int USER_ENABLE    = 1,
    parameter int M_COUNT        = 4,
    parameter int M_DEST_WIDTH   = 8,
    parameter int KEY_OFFSET     = 0,
    parameter int KEY_WIDTH      = 8,
    parameter int DROP_UNMATCHED = 1,
    parameter int DEFAULT_PORT   = 0,
    localparam int KEEP_WIDTH    = (DATA_WIDTH + 7) / 8,
    localparam int ID_WIDTH      = 8,
    localparam int USER_WIDTH    = 1,
    localparam int CL            = $clog2(M_COUNT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    input  logic [ID_WIDTH-1:0]        s_axis_tid,
    input  logic [USER_WIDTH-1:0]      s_axis_tuser,
    input  logic [M_DEST_WIDTH-1:0]    s_axis_tdest,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [ID_WIDTH-1:0]        m_axis_tid,
    output logic [USER_WIDTH-1:0]      m_axis_tuser,
    output logic [CL+M_DEST_WIDTH-1:0] m_axis_tdest,
    input  logic                       cfg_wr,
    input  logic [CL-1:0]              cfg_index,
    input  logic                       cfg_valid,
    input  logic [KEY_WIDTH-1:0]       cfg_key,
    input  logic [KEY_WIDTH-1:0]       cfg_mask,
    output logic [STAT_W-1:0]          stat_match,
    output logic [STAT_W-1:0]          stat_drop
);

    localparam int PW = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + USER_WIDTH + 1 + CL + M_DEST_WIDTH;

    state_t                state_q, state_d;
    logic [M_COUNT-1:0]    tbl_vld;
    logic [KEY_WIDTH-1:0]  tbl_key  [M_COUNT];
    logic [KEY_WIDTH-1:0]  tbl_mask [M_COUNT];
    logic [KEY_WIDTH-1:0]  key_field;
    logic                  hit;
    logic [CL-1:0]         hit_idx;
    logic                  head_drop;
    logic [CL-1:0]         head_port;
    logic [CL-1:0]         port_q;
    logic [CL-1:0]         cur_port;
    logic                  fwd;
    logic                  acc;
    logic                  head_acc;
    logic                  skid_s_ready;
    logic [KEEP_WIDTH-1:0] keep_in;
    logic [ID_WIDTH-1:0]   id_in;
    logic [USER_WIDTH-1:0] user_in;
    logic [PW-1:0]         skid_in;
    logic [PW-1:0]         skid_out;
    logic [STAT_W-1:0]     match_q;
    logic [STAT_W-1:0]     drop_q;

    assign key_field = s_axis_tdata[KEY_OFFSET +: KEY_WIDTH];

    // Priority encoder: scan high to low so the lowest matching index wins
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = M_COUNT - 1; i >= 0; i--) begin
            if (tbl_vld[i] && (((key_field ^ tbl_key[i]) & tbl_mask[i]) == '0)) begin
                hit     = 1'b1;
                hit_idx = CL'(i);
            end
        end
    end

    assign head_drop = !hit && (DROP_UNMATCHED != 0);
    assign head_port = hit ? hit_idx : CL'(DEFAULT_PORT);
    assign cur_port  = (state_q == ST_HEAD) ? head_port : port_q;
    assign fwd       = (state_q == ST_PASS) || ((state_q == ST_HEAD) && !head_drop);

    // Ready depends only on registers; a dropped head beat is taken whenever the buffer has room
    assign s_axis_tready = (state_q == ST_DROP) ? 1'b1 : skid_s_ready;
    assign acc           = s_axis_tvalid && s_axis_tready;
    assign head_acc      = acc && (state_q == ST_HEAD);

    // Table valid bits: written one entry at a time, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_vld <= '0;
        end else if (cfg_wr) begin
            tbl_vld[cfg_index] <= cfg_valid;
        end
    end

    // Table key and mask storage, plus the port latched at each frame head
    always_ff @(posedge clk) begin
        if (cfg_wr) begin
            tbl_key[cfg_index]  <= cfg_key;
            tbl_mask[cfg_index] <= cfg_mask;
        end
        if (head_acc) begin
            port_q <= head_port;
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HEAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame state transitions on accepted beats
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HEAD: if (acc && !s_axis_tlast) state_d = head_drop ? ST_DROP : ST_PASS;
            ST_PASS: if (acc && s_axis_tlast)  state_d = ST_HEAD;
            ST_DROP: if (acc && s_axis_tlast)  state_d = ST_HEAD;
            default: state_d = ST_HEAD;
        endcase
    end

    // Saturating frame counters, bumped once per accepted head beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= '0;
            drop_q  <= '0;
        end else if (head_acc) begin
            if (head_drop) drop_q  <= sat_inc(drop_q);
            else           match_q <= sat_inc(match_q);
        end
    end

    assign stat_match = match_q;
    assign stat_drop  = drop_q;

    assign keep_in = (KEEP_ENABLE != 0) ? s_axis_tkeep : {KEEP_WIDTH{1'b1}};
    assign id_in   = (ID_ENABLE != 0)   ? s_axis_tid   : '0;
    assign user_in = (USER_ENABLE != 0) ? s_axis_tuser : '0;
    assign skid_in = {s_axis_tdata, keep_in, id_in, user_in, s_axis_tlast, cur_port, s_axis_tdest};

    axis_skid_reg #(
        .WIDTH (PW)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (skid_in),
        .s_valid (s_axis_tvalid && fwd),
        .s_ready (skid_s_ready),
        .m_data  (skid_out),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tuser, m_axis_tlast, m_axis_tdest} = skid_out;

endmodule

// File: tb/tb_axis_route_tagger.sv
// Directed bench for axis_route_tagger: a drop-unmatched instance and a
// default-port instance share stimulus; expected values are hand-computed.
module tb_axis_route_tagger;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_tdata = '0;
    logic [0:0]  s_tkeep = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready, s_tready2;
    logic        s_tlast = 1'b0;
    logic [7:0]  s_tid = 8'h5A;
    logic [0:0]  s_tuser = 1'b0;
    logic [7:0]  s_tdest = '0;
    logic        en2 = 1'b0;
    logic        s_tvalid2;
    logic [7:0]  m_tdata, m_tdata2;
    logic [0:0]  m_tkeep, m_tkeep2;
    logic        m_tvalid, m_tvalid2;
    logic        m_tready;
    logic        m_tlast, m_tlast2;
    logic [7:0]  m_tid, m_tid2;
    logic [0:0]  m_tuser, m_tuser2;
    logic [9:0]  m_tdest, m_tdest2;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_index = '0;
    logic        cfg_valid = 1'b0;
    logic [7:0]  cfg_key = '0, cfg_mask = '0;
    logic [15:0] stat_match, stat_drop, stat_match2, stat_drop2;

    logic        tog_en = 1'b0, tog_q = 1'b0, m_rdy_set = 1'b1;
    int          checks = 0, failures = 0;

    // captured output beats (written only by the monitors)
    logic [7:0]  cap_data [64];
    logic [9:0]  cap_dest [64];
    logic        cap_last [64];
    logic [0:0]  cap_user [64];
    int          cap_n = 0;
    logic [7:0]  cap2_data [64];
    logic [9:0]  cap2_dest [64];
    int          cap2_n = 0;
    int          stab_n = 0, stab_bad = 0;
    logic        stall_prev = 1'b0;
    logic [7:0]  pd;
    logic [9:0]  pdest;
    logic        pl;
    int          rd = 0;

    assign s_tvalid2 = s_tvalid && en2;
    assign m_tready  = tog_en ? tog_q : m_rdy_set;

    always #5 clk = ~clk;

    axis_route_tagger #(.DROP_UNMATCHED(1), .DEFAULT_PORT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tuser(s_tuser), .s_axis_tdest(s_tdest),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .m_axis_tuser(m_tuser), .m_axis_tdest(m_tdest),
        .cfg_wr(cfg_wr), .cfg_index(cfg_index), .cfg_valid(cfg_valid),
        .cfg_key(cfg_key), .cfg_mask(cfg_mask),
        .stat_match(stat_match), .stat_drop(stat_drop)
    );

    axis_route_tagger #(.DROP_UNMATCHED(0), .DEFAULT_PORT(3)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid2),
        .s_axis_tready(s_tready2), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tuser(s_tuser), .s_axis_tdest(s_tdest),
        .m_axis_tdata(m_tdata2), .m_axis_tkeep(m_tkeep2), .m_axis_tvalid(m_tvalid2),
        .m_axis_tready(1'b1), .m_axis_tlast(m_tlast2), .m_axis_tid(m_tid2),
        .m_axis_tuser(m_tuser2), .m_axis_tdest(m_tdest2),
        .cfg_wr(cfg_wr), .cfg_index(cfg_index), .cfg_valid(cfg_valid),
        .cfg_key(cfg_key), .cfg_mask(cfg_mask),
        .stat_match(stat_match2), .stat_drop(stat_drop2)
    );

    // ready toggler for the stall scenario
    always begin
        @(posedge clk);
        #1;
        tog_q = ~tog_q;
    end

    // monitor for the main instance: capture transfers, watch stability under stall
    always @(negedge clk) begin
        if (m_tvalid && m_tready && cap_n < 64) begin
            cap_data[cap_n] = m_tdata;
            cap_dest[cap_n] = m_tdest;
            cap_last[cap_n] = m_tlast;
            cap_user[cap_n] = m_tuser;
            cap_n++;
        end
        if (stall_prev) begin
            stab_n++;
            if (!m_tvalid || m_tdata !== pd || m_tdest !== pdest || m_tlast !== pl) stab_bad++;
        end
        stall_prev = m_tvalid && !m_tready;
        pd = m_tdata;
        pdest = m_tdest;
        pl = m_tlast;
    end

    // monitor for the default-port instance
    always @(negedge clk) begin
        if (m_tvalid2 && cap2_n < 64) begin
            cap2_data[cap2_n] = m_tdata2;
            cap2_dest[cap2_n] = m_tdest2;
            cap2_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic cfg(input logic [1:0] idx, input logic v, input logic [7:0] key, input logic [7:0] mask);
        @(posedge clk);
        #1;
        cfg_wr = 1'b1; cfg_index = idx; cfg_valid = v; cfg_key = key; cfg_mask = mask;
        @(posedge clk);
        #1;
        cfg_wr = 1'b0;
    endtask

    // drive one beat and hold it until accepted (bounded)
    task automatic send(input logic [7:0] d, input logic last, input logic [7:0] dest, input logic usr);
        int waits;
        s_tdata = d; s_tlast = last; s_tdest = dest; s_tuser = usr; s_tvalid = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (s_tready && (!en2 || s_tready2)) break;
            waits++;
            if (waits > 50) begin
                chk("send_timeout", 32'(waits), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_stat_match", 32'(stat_match), 32'd0);
        chk("rst_stat_drop", 32'(stat_drop), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("tready_before_edge", 32'(s_tready), 32'd0);
        idle(1);
        chk("tready_after_edge", 32'(s_tready), 32'd1);

        // basic 3-beat frame routed to port 2
        cfg(2'd2, 1'b1, 8'hA5, 8'hFF);
        rd = cap_n;
        send(8'hA5, 1'b0, 8'h07, 1'b1);
        send(8'h11, 1'b0, 8'h07, 1'b0);
        send(8'h22, 1'b1, 8'h07, 1'b0);
        idle(5);
        chk("s1_count", 32'(cap_n - rd), 32'd3);
        chk("s1_d0", 32'(cap_data[rd]), 32'hA5);
        chk("s1_d2", 32'(cap_data[rd+2]), 32'h22);
        chk("s1_dest0", 32'(cap_dest[rd]), 32'h207);
        chk("s1_dest2", 32'(cap_dest[rd+2]), 32'h207);
        chk("s1_last1", 32'(cap_last[rd+1]), 32'd0);
        chk("s1_last2", 32'(cap_last[rd+2]), 32'd1);
        chk("s1_user0", 32'(cap_user[rd]), 32'd1);
        chk("s1_keep", 32'(m_tkeep), 32'd1);
        chk("s1_tid", 32'(m_tid), 32'd0);
        chk("s1_stat_match", 32'(stat_match), 32'd1);

        // two matching entries: lowest index wins; single-beat frame
        cfg(2'd1, 1'b1, 8'h3C, 8'hFF);
        cfg(2'd3, 1'b1, 8'h3C, 8'h0F);
        rd = cap_n;
        send(8'h3C, 1'b1, 8'h12, 1'b0);
        idle(4);
        chk("s2_count", 32'(cap_n - rd), 32'd1);
        chk("s2_dest", 32'(cap_dest[rd]), 32'h112);
        chk("s2_stat_match", 32'(stat_match), 32'd2);

        // unmatched 4-beat frame: dropped by dut, default port 3 on dut2
        rd = cap_n;
        en2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send((i == 0) ? 8'h50 : 8'(i), (i == 3), 8'h05, 1'b0);
            #1;
            chk("s3_tready_held", 32'(s_tready), 32'd1);
        end
        en2 = 1'b0;
        idle(5);
        chk("s3_no_output", 32'(cap_n - rd), 32'd0);
        chk("s3_stat_drop", 32'(stat_drop), 32'd1);
        chk("s3_stat_match", 32'(stat_match), 32'd2);
        chk("s3_dflt_count", 32'(cap2_n), 32'd4);
        chk("s3_dflt_dest", 32'(cap2_dest[0]), 32'h305);
        chk("s3_dflt_d3", 32'(cap2_data[3]), 32'h03);
        chk("s3_dflt_stat", 32'(stat_match2), 32'd1);

        // continuous traffic against a toggling ready
        rd = cap_n;
        tog_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send((i == 0) ? 8'hA5 : 8'(i), (i == 7), 8'h01, 1'b0);
        end
        idle(20);
        tog_en = 1'b0;
        idle(2);
        chk("s4_count", 32'(cap_n - rd), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("s4_order", 32'(cap_data[rd+i]), (i == 0) ? 32'hA5 : 32'(i));
        end
        chk("s4_dest", 32'(cap_dest[rd+7]), 32'h201);
        chk("s4_last", 32'(cap_last[rd+7]), 32'd1);
        chk("s4_stalls_seen", 32'(stab_n > 0), 32'd1);
        chk("s4_stable", 32'(stab_bad), 32'd0);

        // table rewrite mid-frame leaves the current frame's port alone
        rd = cap_n;
        send(8'hA5, 1'b0, 8'h04, 1'b0);
        cfg(2'd0, 1'b1, 8'h00, 8'h00);
        send(8'h77, 1'b0, 8'h04, 1'b0);
        send(8'h88, 1'b1, 8'h04, 1'b0);
        send(8'hA5, 1'b1, 8'h0B, 1'b0);
        idle(5);
        chk("s5_count", 32'(cap_n - rd), 32'd4);
        chk("s5_dest_head", 32'(cap_dest[rd]), 32'h204);
        chk("s5_dest_tail", 32'(cap_dest[rd+2]), 32'h204);
        chk("s5_next_frame", 32'(cap_dest[rd+3]), 32'h00B);
        chk("s5_stat_match", 32'(stat_match), 32'd5);

        // reset mid-frame, then a clean frame
        send(8'hA5, 1'b0, 8'h06, 1'b0);
        send(8'h33, 1'b0, 8'h06, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("s6_rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("s6_rst_tready", 32'(s_tready), 32'd0);
        chk("s6_rst_match", 32'(stat_match), 32'd0);
        chk("s6_rst_drop", 32'(stat_drop), 32'd0);
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        cfg(2'd2, 1'b1, 8'hA5, 8'hFF);
        rd = cap_n;
        send(8'hA5, 1'b0, 8'h09, 1'b0);
        send(8'h42, 1'b1, 8'h09, 1'b0);
        idle(5);
        chk("s6_count", 32'(cap_n - rd), 32'd2);
        chk("s6_dest0", 32'(cap_dest[rd]), 32'h209);
        chk("s6_d1", 32'(cap_data[rd+1]), 32'h42);
        chk("s6_stat_match", 32'(stat_match), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
